prog_load_arbiter: RTL and testbench

- Arbitrates the single-cycle CPU's data memory write port between the CPU datapath and a UART byte-stream program loader.
- In program mode it holds the CPU in reset, packs received bytes into 32-bit big-endian words and writes them to consecutive word addresses.
- It returns the memory port to the CPU when loading completes.
- Sits between MemOrIO/CPU write signals and dmemory32, clocked by cpu_clk.

---
 rtl/prog_load_arbiter.sv | 151 +++++++++++++++
 tb/tb_prog_load_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_arbiter.sv
// Data-memory write-port arbiter: CPU path in IDLE, UART byte-stream program loader in LOAD.
// Optional byte checksum of the loaded stream is built when LOADER_CHECKSUM_EN is defined.
module prog_load_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 16384,
    parameter int TIMEOUT = 100000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start_pg,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        checksum,
    output logic [1:0]        state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                timer_run_q, timer_run_d;
    logic                wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                last_write;
    logic                byte_ok;

    // The write that fills the memory also blocks any byte arriving with it.
    assign last_write = wr_pend_q && ((word_count_q + (ADDR_W+1)'(1)) == (ADDR_W+1)'(DEPTH));
    assign byte_ok    = rx_valid && !last_write;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        timer_d      = timer_q;
        timer_run_d  = timer_run_q;
        wr_pend_d    = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_count_d = word_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pg) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    asm_d        = '0;
                    timer_d      = '0;
                    timer_run_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (wr_pend_q) begin
                    word_count_d = word_count_q + (ADDR_W+1)'(1);
                    if (last_write) state_d = ST_DONE;
                end
                if (byte_ok) begin
                    asm_d       = {asm_q[15:0], rx_byte};
                    byte_idx_d  = byte_idx_q + 2'd1;
                    timer_d     = '0;
                    timer_run_d = 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        wr_pend_d = 1'b1;
                        addr_d    = word_count_q[ADDR_W-1:0];
                        wdata_d   = {asm_q, rx_byte};
                    end
                end else if (timer_run_q && !last_write) begin
                    // A byte on the expiry cycle takes the branch above and keeps the load alive.
                    if (timer_q == TW'(TIMEOUT)) state_d = ST_DONE;
                    else                         timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            timer_q      <= '0;
            timer_run_q  <= 1'b0;
            wr_pend_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            timer_q      <= timer_d;
            timer_run_q  <= timer_run_d;
            wr_pend_q    <= wr_pend_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_count_q <= word_count_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == ST_IDLE && start_pg)     checksum_d = '0;
        else if (state_q == ST_LOAD && byte_ok) checksum_d = checksum_q + rx_byte;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    // Outside IDLE the CPU is cut off; address/data hold the last loader word.
    assign mem_write  = (state_q == ST_IDLE) ? cpu_mem_write : ((state_q == ST_LOAD) && wr_pend_q);
    assign mem_addr   = (state_q == ST_IDLE) ? cpu_addr  : addr_q;
    assign mem_wdata  = (state_q == ST_IDLE) ? cpu_wdata : wdata_q;
    assign cpu_hold   = (state_q != ST_IDLE);
    assign busy       = (state_q == ST_LOAD);
    assign load_done  = (state_q == ST_DONE);
    assign word_count = word_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_prog_load_arbiter.sv
// Directed bench for prog_load_arbiter (DEPTH=4, TIMEOUT=8); checksum expectations follow LOADER_CHECKSUM_EN.
module tb_prog_load_arbiter;

    localparam int ADDR_W  = 14;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int W       = ADDR_W + 32;

    logic              clock;
    logic              rst;
    logic              start_pg;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        checksum;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_w;
    logic [31:0]   mem_model [int];

    prog_load_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .rst(rst), .start_pg(start_pg), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
        .word_count(word_count), .checksum(checksum), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] cs(input logic [7:0] v);
`ifdef LOADER_CHECKSUM_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_load();
        start_pg = 1'b1;
        tick();
        start_pg = 1'b0;
    endtask

    // scoreboard: every loader write is matched in order against exp_q
    always @(negedge clock) begin
        if (!rst && busy && mem_write) begin
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL write_expected: observed write %0h expected no write", {mem_addr, mem_wdata});
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("write_word", {mem_addr, mem_wdata}, exp_w);
                mem_model[int'(mem_addr)] = mem_wdata;
            end
        end
    end

    initial begin
        rst = 1'b1; start_pg = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_word_count", word_count, 0);
        check("rst_checksum", checksum, 0);
        check("rst_state", state_dbg, 0);
        tick();
        rst = 1'b0;

        // IDLE pass-through, zero latency
        cpu_mem_write = 1'b1; cpu_addr = 14'd5; cpu_wdata = 32'hDEADBEEF;
        #1;
        check("idle_mem_write", mem_write, 1);
        check("idle_mem_addr", mem_addr, 5);
        check("idle_mem_wdata", mem_wdata, 32'hDEADBEEF);

        // two full words, CPU keeps requesting writes throughout
        exp_q.push_back({14'd0, 32'h12345678});
        exp_q.push_back({14'd1, 32'hABCDEF01});
        start_load();
        #1;
        check("load_busy", busy, 1);
        check("load_cpu_hold", cpu_hold, 1);
        check("load_cpu_blocked", mem_write, 0);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        #1;
        check("no_write_partial", mem_write, 0);
        send_byte(8'h78);
        #1;
        check("wr_cycle_write", mem_write, 1);
        check("wr_cycle_addr", mem_addr, 0);
        check("wr_cycle_data", mem_wdata, 32'h12345678);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
        repeat (TIMEOUT) tick();
        check("pre_timeout_busy", busy, 1);
        check("pre_timeout_done", load_done, 0);
        tick();
        check("done_pulse", load_done, 1);
        check("done_cpu_hold", cpu_hold, 1);
        check("done_busy", busy, 0);
        check("done_word_count", word_count, 2);
        check("done_checksum", checksum, cs(8'h7C));
        check("done_all_written", exp_q.size(), 0);
        tick();
        check("after_done_pulse", load_done, 0);
        check("after_done_hold", cpu_hold, 0);
        check("after_done_mirror_we", mem_write, 1);
        check("after_done_mirror_d", mem_wdata, 32'hDEADBEEF);

        // partial trailing word is dropped
        cpu_mem_write = 1'b0;
        exp_q.push_back({14'd0, 32'h01020304});
        start_load();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        repeat (TIMEOUT + 1) tick();
        check("partial_done", load_done, 1);
        check("partial_word_count", word_count, 1);
        check("partial_checksum", checksum, cs(8'h0F));
        check("partial_all_written", exp_q.size(), 0);
        tick();
        check("partial_idle", cpu_hold, 0);

        // byte on the expiry cycle keeps the load going
        exp_q.push_back({14'd0, 32'hAABBCCDD});
        start_load();
        send_byte(8'hAA);
        repeat (TIMEOUT) tick();
        check("expiry_cycle_busy", busy, 1);
        send_byte(8'hBB);
        check("byte_wins_busy", busy, 1);
        tick();
        check("byte_wins_still_busy", busy, 1);
        send_byte(8'hCC); send_byte(8'hDD);
        repeat (TIMEOUT + 1) tick();
        check("expiry_done", load_done, 1);
        check("expiry_word_count", word_count, 1);
        check("expiry_checksum", checksum, cs(8'h0E));
        tick();

        // memory fills at DEPTH words; later bytes ignored
        exp_q.push_back({14'd0, 32'h10111213});
        exp_q.push_back({14'd1, 32'h14151617});
        exp_q.push_back({14'd2, 32'h18191A1B});
        exp_q.push_back({14'd3, 32'h1C1D1E1F});
        start_load();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        #1;
        check("full_last_write", mem_write, 1);
        check("full_last_addr", mem_addr, 3);
        send_byte(8'h20);
        check("full_done", load_done, 1);
        check("full_word_count", word_count, 4);
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
        check("full_idle", cpu_hold, 0);
        check("full_busy", busy, 0);
        check("full_count_held", word_count, 4);
        check("full_checksum", checksum, cs(8'h78));
        check("full_all_written", exp_q.size(), 0);

        // reset during the third byte of the second word
        exp_q.push_back({14'd0, 32'h11223344});
        start_load();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rx_valid = 1'b1; rx_byte = 8'h77; rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_cpu_hold", cpu_hold, 0);
        check("midrst_word_count", word_count, 0);
        check("midrst_checksum", checksum, 0);
        check("midrst_state", state_dbg, 0);
        check("midrst_mem0_kept", mem_model[0], 32'h11223344);
        check("midrst_all_written", exp_q.size(), 0);
        tick();
        rx_valid = 1'b0; rst = 1'b0;
        cpu_mem_write = 1'b1; cpu_addr = 14'd7; cpu_wdata = 32'hCAFEF00D;
        #1;
        check("post_rst_addr", mem_addr, 7);
        check("post_rst_data", mem_wdata, 32'hCAFEF00D);
        tick();
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
